// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the instruction-memory UART loader:
// FSM state encoding, error codes and the default frame start marker.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] START_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_uart_loader_timeout.sv
// Idle-cycle watchdog for UART-facing blocks. The count restarts on clr and
// advances while en is high. expired is high during the cycle whose closing
// edge completes LIMIT idle cycles since the last clear, so a caller that
// acts on it at that edge times out exactly LIMIT cycles after the clear.
module loader_timeout #(
  parameter int LIMIT = 1000000,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count;

  assign expired = en && (count == W'(LIMIT - 1));

  // Idle counter: clear wins, then count while enabled, holding at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != W'(LIMIT - 1))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a framed program image from the UART byte stream into instruction
// memory: A5, LEN_HI, LEN_LO, LEN*4 big-endian data bytes, XOR checksum.
// Handshake: rx_valid is a one-cycle strobe with no ready/backpressure; every
// cycle with rx_valid=1 delivers exactly one byte on rx_data, which the FSM
// always consumes in that cycle. wr_en is a one-cycle write strobe with no
// ready; the memory must accept the word in the cycle wr_en is high.
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int         MEM_WORDS      = 64,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] START_BYTE     = START_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [30:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [1:0]  err_code,
  output logic [2:0]  dbg_state
);

  localparam int WI = $clog2(MEM_WORDS) + 1;

  state_t        state;
  logic [15:0]   len;
  logic [15:0]   len_next;
  logic [WI-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_q;
  logic [7:0]    chk;
  logic          last_word;
  logic          in_frame;
  logic          expired;

  assign dbg_state = state;
  assign len_next  = {len[15:8], rx_data};
  assign last_word = ({{(16-WI){1'b0}}, word_idx} + 16'd1) == len;
  assign in_frame  = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == DATA)   || (state == CHECK);

  // Every state entry coincides with a consumed byte or leaves the counting
  // states, so clearing on rx_valid or outside a frame covers both restarts.
  loader_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (rx_valid || !in_frame),
    .en      (in_frame),
    .expired (expired)
  );

  // Frame FSM with word assembly, running checksum and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len       <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      asm_q     <= '0;
      chk       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      wr_en <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (rx_data == START_BYTE) begin
              state     <= LEN_HI;
              cpu_hold  <= 1'b1;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              err_code  <= ERR_NONE;
            end
          end
          LEN_HI: begin
            len[15:8] <= rx_data;
            chk       <= rx_data;
            state     <= LEN_LO;
          end
          LEN_LO: begin
            len[7:0] <= rx_data;
            chk      <= chk ^ rx_data;
            word_idx <= '0;
            byte_idx <= '0;
            if ((len_next == 16'd0) || (len_next > 16'(MEM_WORDS))) begin
              state    <= ERROR;
              load_err <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            chk      <= chk ^ rx_data;
            asm_q    <= {asm_q[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= 31'({word_idx, 2'b00});
              wr_data  <= {asm_q, rx_data};
              word_idx <= word_idx + 1'b1;
              if (last_word) state <= CHECK;
            end
          end
          CHECK: begin
            if (rx_data == chk) begin
              state     <= DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
              err_code <= ERR_CHK;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (expired) begin
        state    <= ERROR;
        load_err <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: framed loads, length bounds, checksum
// error, timeout edge, noise, restart and asynchronous reset mid-frame.
module tb_imem_uart_loader;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [30:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  logic [30:0] last_addr = '0;
  logic        wr_en_prev = 1'b0;
  logic [62:0] exp_q[$];
  logic [7:0]  bq[$];

  imem_uart_loader #(
    .MEM_WORDS      (64),
    .TIMEOUT_CYCLES (100),
    .START_BYTE     (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: called at posedge+1, return at posedge+1 after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_q();
    while (bq.size() > 0) send_byte(bq.pop_front());
  endtask

  function automatic logic [31:0] pattern_word(input int i);
    return (32'h01020304 * 32'(i + 1)) ^ 32'hA5A55A5A;
  endfunction

  // Full frame of n pattern words; expected writes are queued, chk optionally corrupted.
  task automatic send_pattern_frame(input int n, input logic [7:0] chk_flip);
    logic [7:0]  c;
    logic [31:0] w;
    logic [15:0] l;
    l = 16'(n);
    c = l[15:8] ^ l[7:0];
    bq.push_back(8'hA5);
    bq.push_back(l[15:8]);
    bq.push_back(l[7:0]);
    for (int i = 0; i < n; i++) begin
      w = pattern_word(i);
      exp_q.push_back({31'(i * 4), w});
      for (int k = 3; k >= 0; k--) begin
        bq.push_back(w[k*8 +: 8]);
        c = c ^ w[k*8 +: 8];
      end
    end
    bq.push_back(c ^ chk_flip);
    send_q();
  endtask

  // Scoreboard: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (wr_en) begin
      check("wr_spacing", {63'd0, wr_en_prev}, 64'd0);
      n_writes++;
      last_addr = wr_addr;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {33'd0, wr_addr}, 64'hFFFF_FFFF);
      end else begin
        logic [62:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {33'd0, wr_addr}, {33'd0, e[62:32]});
        check("wr_data", {32'd0, wr_data}, {32'd0, e[31:0]});
      end
    end
    wr_en_prev = wr_en;
  end

  initial begin
    int w0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_wr_en", wr_en, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_state", dbg_state, S_IDLE);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // noise in IDLE
    bq = '{8'h00, 8'hFF, 8'h3C};
    send_q();
    check("noise_state", dbg_state, S_IDLE);
    check("noise_hold", cpu_hold, 0);

    // directed good frame, checksum hand-computed as 0xD2
    exp_q.push_back({31'h0, 32'h3C084000});
    exp_q.push_back({31'h4, 32'h8D090020});
    send_byte(8'hA5);
    check("good_hold_after_start", cpu_hold, 1);
    bq = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h40, 8'h00, 8'h8D, 8'h09, 8'h00, 8'h20, 8'hD2};
    send_q();
    check("good_done", load_done, 1);
    check("good_hold", cpu_hold, 0);
    check("good_err_code", err_code, 0);
    check("good_writes", n_writes, 2);

    // reload from DONE
    exp_q.push_back({31'h0, 32'h3C084000});
    exp_q.push_back({31'h4, 32'h8D090020});
    send_byte(8'hA5);
    check("reload_hold_after_start", cpu_hold, 1);
    check("reload_done_cleared", load_done, 0);
    bq = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h40, 8'h00, 8'h8D, 8'h09, 8'h00, 8'h20, 8'hD2};
    send_q();
    check("reload_done", load_done, 1);
    check("reload_writes", n_writes, 4);

    // length 0
    bq = '{8'hA5, 8'h00, 8'h00};
    send_q();
    check("len0_err", load_err, 1);
    check("len0_code", err_code, 1);
    check("len0_hold", cpu_hold, 1);
    check("len0_done", load_done, 0);

    // length 65
    bq = '{8'hA5, 8'h00, 8'h41};
    send_q();
    check("len65_err", load_err, 1);
    check("len65_code", err_code, 1);
    check("len_writes", n_writes, 4);

    // maximum length 64
    w0 = n_writes;
    send_pattern_frame(64, 8'h00);
    check("len64_writes", n_writes - w0, 64);
    check("len64_last_addr", {33'd0, last_addr}, 64'hFC);
    check("len64_done", load_done, 1);
    check("len64_err", load_err, 0);

    // bad checksum (0xD3)
    exp_q.push_back({31'h0, 32'h3C084000});
    exp_q.push_back({31'h4, 32'h8D090020});
    w0 = n_writes;
    bq = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h08, 8'h40, 8'h00, 8'h8D, 8'h09, 8'h00, 8'h20, 8'hD3};
    send_q();
    check("badchk_writes", n_writes - w0, 2);
    check("badchk_err", load_err, 1);
    check("badchk_code", err_code, 2);
    check("badchk_hold", cpu_hold, 1);
    check("badchk_state", dbg_state, S_ERROR);

    // timeout: silence after the last byte
    bq = '{8'hA5, 8'h00, 8'h01, 8'h3C};
    send_q();
    check("to_restart_err_cleared", err_code, 0);
    repeat (99) @(posedge clk);
    #1;
    check("to_before_limit", dbg_state, S_DATA);
    @(posedge clk);
    #1;
    check("to_state", dbg_state, S_ERROR);
    check("to_code", err_code, 3);
    check("to_hold", cpu_hold, 1);

    // byte on the limit cycle wins over the timeout
    exp_q.push_back({31'h0, 32'h3C084000});
    bq = '{8'hA5, 8'h00, 8'h01, 8'h3C};
    send_q();
    repeat (99) @(posedge clk);
    #1;
    send_byte(8'h08);
    check("edge_state", dbg_state, S_DATA);
    check("edge_err", load_err, 0);
    bq = '{8'h40, 8'h00, 8'h75};
    send_q();
    check("edge_done", dbg_state, S_DONE);
    check("edge_load_done", load_done, 1);

    // asynchronous reset after two words of a four-word frame
    exp_q.push_back({31'h0, 32'h11223344});
    exp_q.push_back({31'h4, 32'h55667788});
    bq = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_q();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_hold", cpu_hold, 0);
    check("mid_rst_state", dbg_state, S_IDLE);
    check("mid_rst_addr", {33'd0, wr_addr}, 0);
    check("mid_rst_data", {32'd0, wr_data}, 0);
    check("mid_rst_done", load_done, 0);
    check("mid_rst_err", load_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_pattern_frame(3, 8'h00);
    check("post_rst_done", load_done, 1);
    check("post_rst_hold", cpu_hold, 0);
    repeat (2) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
